// File: rtl/sseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sseg_scan_driver
//   Feeds the BCD_to_sseg decoder of the parking-lot display. A binary count
//   is converted to BCD by a sequential double-dabble engine, and the
//   resulting digits are time-multiplexed onto the display.
//
// Ports
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   value        binary number to display
//   load         one-cycle strobe: sample value and start a conversion
//   dp_mask      decimal-point bit per digit, passed raw into hex.dp
//   blank_zeros  1 = suppress leading zeros
//   hex          digit + dp for the active slot (to the decoder)
//   anode        active-low digit enables, one-hot-zero
//   busy         conversion in progress
//   overflow     last taken value exceeded 9999 (display saturated)
// ---------------------------------------------------------------------------
package sseg_scan_pkg;
  typedef struct packed {
    logic [3:0] digito;
    logic       dp;
  } BCDnumber_t;
endpackage

module sseg_scan_driver
  import sseg_scan_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int BIN_W       = 14,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BIN_W-1:0]    value,
  input  logic                load,
  input  logic [N_DIGITS-1:0] dp_mask,
  input  logic                blank_zeros,
  output BCDnumber_t          hex,
  output logic [N_DIGITS-1:0] anode,
  output logic                busy,
  output logic                overflow
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [BIN_W-1:0] MAX_VAL  = BIN_W'(9999);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [PRE_W-1:0] PRE_TC   = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                     state_r;
  logic [CNT_W-1:0]           cnt_r;
  logic [BIN_W-1:0]           bin_r;
  logic [N_DIGITS-1:0][3:0]   bcd_r;
  logic [N_DIGITS-1:0][3:0]   digits_r;
  logic [BIN_W-1:0]           pend_val_r;
  logic                       pend_v_r;

  logic [PRE_W-1:0]           pre_r;
  logic [IDX_W-1:0]           idx_r;

  logic [BIN_W-1:0]           src_s;
  logic [BIN_W-1:0]           start_bin_s;
  logic                       start_ovf_s;
  logic                       restart_s;
  logic [IDX_W-1:0]           idx_nxt_s;
  logic                       upper_zero_s;
  logic                       blank_s;

  // Double-dabble correction: every BCD nibble >= 5 gets 3 added before the shift.
  function automatic logic [N_DIGITS-1:0][3:0] dabble_adjust(input logic [N_DIGITS-1:0][3:0] bcd);
    logic [N_DIGITS-1:0][3:0] res;
    for (int i = 0; i < N_DIGITS; i++) begin
      res[i] = (bcd[i] >= 4'd5) ? (bcd[i] + 4'd3) : bcd[i];
    end
    return res;
  endfunction

  // Pick the value for a new conversion and saturate it to the displayable range.
  // In COMMIT a fresh load beats the stored pending value (last one wins).
  always_comb begin
    src_s       = value;
    start_bin_s = value;
    start_ovf_s = 1'b0;
    restart_s   = load | pend_v_r;
    if ((state_r == ST_COMMIT) && !load) begin
      src_s = pend_val_r;
    end else begin
      src_s = value;
    end
    if (src_s > MAX_VAL) begin
      start_ovf_s = 1'b1;
      start_bin_s = MAX_VAL;
    end else begin
      start_ovf_s = 1'b0;
      start_bin_s = src_s;
    end
  end

  // Conversion FSM: IDLE -> SHIFT (BIN_W cycles) -> COMMIT -> IDLE or next SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      bin_r      <= '0;
      bcd_r      <= '0;
      digits_r   <= '0;
      pend_val_r <= '0;
      pend_v_r   <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            bin_r    <= start_bin_s;
            bcd_r    <= '0;
            overflow <= start_ovf_s;
            cnt_r    <= '0;
            busy     <= 1'b1;
            state_r  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd_r, bin_r} <= {dabble_adjust(bcd_r), bin_r} << 1;
          if (load) begin
            pend_val_r <= value;
            pend_v_r   <= 1'b1;
          end
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_COMMIT;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          digits_r <= bcd_r;
          pend_v_r <= 1'b0;
          if (restart_s) begin
            bin_r    <= start_bin_s;
            bcd_r    <= '0;
            overflow <= start_ovf_s;
            cnt_r    <= '0;
            state_r  <= ST_SHIFT;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Next slot index and leading-zero blanking decision for that slot.
  always_comb begin
    idx_nxt_s    = (idx_r == IDX_LAST) ? '0 : (idx_r + IDX_W'(1));
    upper_zero_s = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      upper_zero_s = upper_zero_s & ~((i >= int'(idx_nxt_s)) && (digits_r[i] != 4'd0));
    end
    blank_s = blank_zeros && (idx_nxt_s != '0) && upper_zero_s;
  end

  // Refresh scanner: advances the slot and re-registers the outputs at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r  <= '0;
      idx_r  <= '0;
      anode  <= {{(N_DIGITS-1){1'b1}}, 1'b0};
      hex    <= '0;
    end else begin
      if (pre_r == PRE_TC) begin
        pre_r      <= '0;
        idx_r      <= idx_nxt_s;
        anode      <= blank_s ? '1 : ~(N_DIGITS'(1) << idx_nxt_s);
        hex.digito <= blank_s ? 4'd0 : digits_r[idx_nxt_s];
        hex.dp     <= dp_mask[idx_nxt_s];
      end else begin
        pre_r <= pre_r + PRE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
module tb_sseg_scan_driver;
  import sseg_scan_pkg::*;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [13:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dp_mask = '0;
  logic        blank_zeros = 1'b0;
  BCDnumber_t  hex;
  logic [3:0]  anode;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  // Reference model state: time-based, decimal arithmetic
  int   k;
  int   m_digits [4];
  bit   m_busy, m_ovf, m_pend_v;
  int   m_pend_val, m_conv_val, m_conv_end;
  logic [3:0] m_anode, m_digito;
  logic m_dp;

  sseg_scan_driver #(.N_DIGITS(4), .BIN_W(14), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_mask(dp_mask),
    .blank_zeros(blank_zeros), .hex(hex), .anode(anode), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 4; i++) m_digits[i] = 0;
    m_busy = 0; m_ovf = 0; m_pend_v = 0;
    m_pend_val = 0; m_conv_val = 0; m_conv_end = 0;
    m_anode = 4'b1110; m_digito = 4'd0; m_dp = 1'b0;
  endtask

  task automatic model_start(input int v);
    m_ovf      = (v > 9999);
    m_conv_val = (v > 9999) ? 9999 : v;
    m_conv_end = k + 15;
    m_busy     = 1;
  endtask

  // Advance the model by one rising edge using the inputs the DUT sampled.
  task automatic model_edge();
    int slot;
    bit blank;
    int div;
    logic [3:0] one;
    k++;
    if (k % DIV == 0) begin
      slot  = (k / DIV) % 4;
      blank = 0;
      if (blank_zeros && slot > 0) begin
        blank = 1;
        for (int j = slot; j < 4; j++) if (m_digits[j] != 0) blank = 0;
      end
      one      = 4'b0001;
      m_anode  = blank ? 4'b1111 : ~(one << slot);
      m_digito = blank ? 4'd0 : 4'(m_digits[slot]);
      m_dp     = dp_mask[slot];
    end
    if (m_busy) begin
      if (k == m_conv_end) begin
        div = 1;
        for (int i = 0; i < 4; i++) begin
          m_digits[i] = (m_conv_val / div) % 10;
          div = div * 10;
        end
        if (load) model_start(int'(value));
        else if (m_pend_v) model_start(m_pend_val);
        else m_busy = 0;
        m_pend_v = 0;
      end else if (load) begin
        m_pend_v   = 1;
        m_pend_val = int'(value);
      end
    end else if (load) begin
      model_start(int'(value));
    end
  endtask

  task automatic compare();
    chk("anode", int'(anode), int'(m_anode));
    chk("digito", int'(hex.digito), int'(m_digito));
    chk("dp", int'(hex.dp), int'(m_dp));
    chk("busy", int'(busy), int'(m_busy));
    chk("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_value(input int v);
    value = 14'(v);
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic wait_anode(input logic [3:0] pat, input int exp_d, input string name);
    int n;
    n = 0;
    while (anode !== pat && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_found"}, int'(anode === pat), 1);
    if (anode === pat) chk(name, int'(hex.digito), exp_d);
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int n;
    int cnt_a, cnt_b;
    bit saw [10];

    // Reset state
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_anode", int'(anode), 4'b1110);
    chk("rst_digito", int'(hex.digito), 0);
    chk("rst_dp", int'(hex.dp), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    release_reset();

    // Free-running scan with no load
    tick_n(20);
    chk("scan_k20_anode", int'(anode), 4'b1101);
    tick_n(4);
    chk("scan_k24_anode", int'(anode), 4'b1011);

    // 1234: busy length and digit placement
    load_value(1234);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("busy_cycles", n, 15);
    chk("model_d0", m_digits[0], 4);
    chk("model_d3", m_digits[3], 1);
    tick_n(20);
    wait_anode(4'b1110, 4, "d1234_slot0");
    wait_anode(4'b1101, 3, "d1234_slot1");
    wait_anode(4'b1011, 2, "d1234_slot2");
    wait_anode(4'b0111, 1, "d1234_slot3");

    // 7 with leading-zero blanking
    blank_zeros = 1'b1;
    load_value(7);
    tick_n(40);
    wait_anode(4'b1110, 7, "blank_slot0");
    cnt_a = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (anode === 4'b1111) cnt_a++;
    end
    chk("blank_cycles", cnt_a, 12);

    // Saturation and overflow clear
    blank_zeros = 1'b0;
    load_value(12000);
    tick_n(2);
    chk("ovf_set", int'(overflow), 1);
    tick_n(36);
    wait_anode(4'b0111, 9, "sat_slot3");
    wait_anode(4'b1110, 9, "sat_slot0");
    load_value(5);
    chk("ovf_clear", int'(overflow), 0);
    tick_n(36);

    // Loads while busy: last pending wins, middle value never shown
    load_value(1111);
    tick_n(2);
    load_value(2222);
    tick_n(2);
    load_value(3333);
    for (int i = 0; i < 10; i++) saw[i] = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (anode !== 4'b1111) saw[hex.digito % 10] = 1;
    end
    chk("pend_saw1111", int'(saw[1]), 1);
    chk("pend_saw2222", int'(saw[2]), 0);
    chk("pend_saw3333", int'(saw[3]), 1);

    // Decimal point follows its slot
    dp_mask = 4'b0100;
    tick_n(20);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (hex.dp === 1'b1) cnt_a++;
      if (hex.dp === 1'b1 && anode !== 4'b1011) cnt_b++;
    end
    chk("dp_on_cycles", cnt_a, 4);
    chk("dp_wrong_slot", cnt_b, 0);
    dp_mask = 4'b0000;
    tick_n(16);

    // Reset in the middle of a conversion with a pending value
    load_value(4321);
    tick_n(3);
    load_value(8888);
    tick_n(2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_anode", int'(anode), 4'b1110);
    chk("midrst_digito", int'(hex.digito), 0);
    chk("midrst_overflow", int'(overflow), 0);
    release_reset();
    tick_n(40);
    chk("post_rst_busy", int'(busy), 0);
    wait_anode(4'b0111, 0, "post_rst_slot3");
    wait_anode(4'b1101, 0, "post_rst_slot1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
